adder_pipe_scheduler: RTL and testbench
=======================================

// Module: adder_pipe_scheduler
// PURPOSE
// - Shares one 4-stage stallable 32-bit pipelined adder among NREQ requesters.
// - Round-robin arbitration; one issue per cycle into adder stage 1.
// - Carries valid+requester tag in a shadow pipeline alongside the adder.
// - Drives the adder's stop from a valid/ready response handshake.
// PARAMETERS
// - NREQ  4   number of requesters (2..8)
// - W     32  operand width; must match the adder
// - LAT   4   adder latency in cycles, issue edge to sum/c_out valid
// - IDW   2   tag width, clog2(NREQ)
// PORTS
// - clk        in   1        clock, all logic on posedge
// - rst        in   1        synchronous active-high reset; same net drives the adder rst
// - req_valid  in   NREQ     requester i has an operation pending
// - req_ready  out  NREQ     one-hot grant; handshake on req_valid[i] & req_ready[i]
// - req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
// - req_b      in   NREQ*W   operand B, same packing
// - req_cin    in   NREQ     carry-in per requester
// - add_a      out  W        to adder cin_a
// - add_b      out  W        to adder cin_b
// - add_cin    out  1        to adder c_in
// - add_stop   out  1        to adder stop
// - add_sum    in   W        from adder sum
// - add_cout   in   1        from adder c_out
// - rsp_valid  out  1        result available
// - rsp_ready  in   1        consumer accepts the result
// - rsp_id     out  IDW      requester that issued this result
// - rsp_sum    out  W        equals add_sum
// - rsp_cout   out  1        equals add_cout
// - busy       out  1        any entry in flight (OR of shadow valids)
// BEHAVIOUR
// - Shadow pipe: vld[0..LAT-1], tag[0..LAT-1]. Shifts exactly when the adder advances.
// - add_stop = vld[LAT-1] & ~rsp_ready (combinational). Stall freezes the whole pipe; bubbles are not collapsed.
// - rsp_valid = vld[LAT-1]; rsp_id = tag[LAT-1]; rsp_sum/rsp_cout are pass-through of add_sum/add_cout.
// - Grant: only when add_stop=0. Pick the first requester with req_valid set, scanning from ptr upward with wrap.
//   - req_ready is one-hot or zero, combinational from req_valid, ptr and add_stop.
//   - No request, or stalled: req_ready=0 and stage 0 loads vld=0.
// - Issue: add_a/add_b/add_cin mux the granted requester's operands. Drive 0 when there is no grant.
//   - The adder captures them on the same edge that vld[0]<=1 and tag[0]<=granted id.
// - ptr <= (granted id + 1) mod NREQ on a grant; it holds otherwise.
// - Latency: op granted at edge k appears with rsp_valid=1 after edge k+LAT-1 (LAT cycles from issue to result).
// - Throughput: 1 op/cycle while rsp_ready=1.
// - Stall release: with rsp_ready=1 the pipe shifts on that edge and arbitration resumes in the same cycle.
// - Simultaneous rsp accept and new grant: both happen on one edge; no lost or duplicated entries.
// - Width: sum is mod 2^W; carry-out goes to rsp_cout; no saturation.
// - Reset (also mid-operation): vld all 0, tag 0, ptr 0. In-flight ops are discarded, never replayed.
//   - Requesters re-request after reset.
// - Reset output values: rsp_valid=0, rsp_id=0, rsp_sum=0 (the adder is also reset), rsp_cout=0, busy=0, add_stop=0,
//   req_ready=0 during rst, add_a/add_b/add_cin=0.
// STRUCTURE
// - Shared package: ADD_W=32, ADD_LAT=4, MAX_REQ=8, and a clog2 function.
// - One sub-module, rr_arbiter: NREQ-wide round-robin with pointer; ports req, en, gnt (one-hot), gnt_id, ptr update.
// - Top holds the shadow valid/tag pipe, operand mux and stop logic. The adder is instantiated outside.
// TESTING (bench instantiates the scheduler together with the real 4-stage adder)
// - Single op: req0 a=0x0000_00FF b=0x0000_0001 cin=0 -> rsp_valid LAT cycles later, sum=0x0000_0100, cout=0, id=0.
// - Carry chain: a=0xFFFF_FFFF b=0 cin=1 -> sum=0, cout=1. Then a=b=0x8000_0000 cin=0 -> sum=0, cout=1.
// - Fairness: all 4 requesters held valid for 8 cycles with rsp_ready=1 -> grants 0,1,2,3,0,1,2,3; rsp_id follows in order.
// - Backpressure: stream of 6 ops, rsp_ready=0 for 3 cycles mid-stream -> add_stop=1, req_ready=0 and rsp held stable;
//   all 6 results delivered once, in order.
// - Bubbles: requests every other cycle -> rsp_valid alternates; busy drops 1 cycle after the last accept.
// - Reset mid-flight: rst pulsed with 3 ops in flight -> next cycle rsp_valid=0, busy=0, ptr=0;
//   new req2 op completes normally.

Source files
------------

// File: rtl/adder_pipe_scheduler_pkg.sv
// Shared constants and helpers for the adder pipe scheduler slice.
//   ADD_W   : operand width of the shared pipelined adder
//   ADD_LAT : adder latency in cycles, issue edge to sum/c_out valid
//   MAX_REQ : largest supported requester count
//   clog2() : ceiling log2, floored at 1 so a tag is never zero bits wide
package adder_pipe_scheduler_pkg;

  localparam int unsigned ADD_W   = 32;
  localparam int unsigned ADD_LAT = 4;
  localparam int unsigned MAX_REQ = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk      : clock
//   rst      : synchronous active-high reset, pointer returns to 0
//   req      : request vector
//   en       : arbitration enable; no grant while low
//   gnt      : one-hot grant (or zero)
//   gnt_id   : binary index of the granted requester (0 when no grant)
//   gnt_any  : a grant is being issued this cycle
// The pointer moves to one past the granted index on each grant and holds otherwise.
module adder_pipe_scheduler_rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_any
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   cand;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (en && !gnt_any && req[cand[IDW-1:0]]) begin
        gnt_any                = 1'b1;
        gnt[cand[IDW-1:0]]     = 1'b1;
        gnt_id                 = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_pipe_scheduler.sv
// Shares one stallable LAT-stage pipelined adder among NREQ requesters.
//   clk, rst                : clock, synchronous active-high reset (same net resets the adder)
//   req_valid/req_ready     : per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b/req_cin     : packed per-requester operands, requester i at [i*W +: W]
//   add_a/add_b/add_cin     : operands of the granted requester into adder stage 1 (0 if none)
//   add_stop                : adder stall, raised when a result waits on rsp_ready
//   add_sum/add_cout        : adder outputs, passed straight through to rsp_sum/rsp_cout
//   rsp_valid/rsp_ready     : result handshake; rsp_id names the issuing requester
//   busy                    : any operation in flight
// A shadow pipe of valid bits and tags moves in lockstep with the adder so each
// result leaving the adder is paired with the requester that issued it.
module adder_pipe_scheduler
  import adder_pipe_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = ADD_W,
  parameter int unsigned LAT  = ADD_LAT,
  parameter int unsigned IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_cin,
  output logic              add_stop,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  logic [LAT-1:0]          vld_q, vld_d;
  logic [LAT-1:0][IDW-1:0] tag_q, tag_d;
  logic                    advance;
  logic                    arb_en;
  logic                    grant_any;
  logic [IDW-1:0]          grant_id;

  // Only a result stuck at the output can stall; bubbles further back are not squeezed out.
  assign add_stop = vld_q[LAT-1] & ~rsp_ready;
  assign advance  = ~add_stop;
  assign arb_en   = advance & ~rst;

  adder_pipe_scheduler_rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (req_ready),
    .gnt_id  (grant_id),
    .gnt_any (grant_any)
  );

  // Grant is one-hot, so at most one requester drives the adder inputs.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        add_a   = req_a[i*W +: W];
        add_b   = req_b[i*W +: W];
        add_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (advance) begin
      vld_d = {vld_q[LAT-2:0], grant_any};
      tag_d = {tag_q[LAT-2:0], grant_id};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = tag_q[LAT-1];
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_adder_pipe_scheduler.sv
module tb_adder_pipe_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned LAT  = 4;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_cin;
  logic              add_stop;
  logic [W-1:0]      add_sum;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;

  int checks = 0;
  int errors = 0;

  adder_pipe_scheduler #(
    .NREQ (NREQ),
    .W    (W),
    .LAT  (LAT),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_stop  (add_stop),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  // 4-stage stallable adder: stage 1 computes, later stages carry the result.
  logic [W:0] st_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) st_q[i] <= '0;
    end else if (!add_stop) begin
      st_q[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
      for (int i = 1; i < LAT; i++) st_q[i] <= st_q[i-1];
    end
  end

  assign add_sum  = st_q[LAT-1][W-1:0];
  assign add_cout = st_q[LAT-1][W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
    req_valid[idx]     = 1'b1;
    req_a[idx*W +: W]  = a;
    req_b[idx*W +: W]  = b;
    req_cin[idx]       = cin;
  endtask

  // Issue one op alone, wait for its result and confirm the pipe drains afterwards.
  task automatic run_single(input int idx, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic [31:0] es, input logic ec);
    int n;
    set_op(idx, a, b, cin);
    #1;
    chk("single_gnt", 64'(req_ready), 64'(4'b0001 << idx));
    chk("single_add_a", 64'(add_a), 64'(a));
    chk("single_add_cin", 64'(add_cin), 64'(cin));
    tick();
    req_valid = '0;
    #1;
    chk("single_busy", 64'(busy), 64'd1);
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("single_latency", 64'(n), 64'(LAT - 1));
    chk("single_sum", 64'(rsp_sum), 64'(es));
    chk("single_cout", 64'(rsp_cout), 64'(ec));
    chk("single_id", 64'(rsp_id), 64'(idx));
    tick();
    chk("single_drain_valid", 64'(rsp_valid), 64'd0);
    chk("single_drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int rc;
    int sent;
    logic hs;
    logic exp_v;
    logic exp_b;

    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    tick();
    tick();

    // Reset state, with a request pending to show no grant leaks out during rst.
    set_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_stop", 64'(add_stop), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    chk("rst_add_cin", 64'(add_cin), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    // Single op and carry chain.
    run_single(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    run_single(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    run_single(3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

    // Fairness: all four held valid for eight grants; pointer starts at 0.
    for (int i = 0; i < 4; i++) set_op(i, 32'(32'h100 * (i + 1)), 32'(i), 1'b0);
    rc = 0;
    for (int c = 0; c < 16 && rc < 8; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) chk("fair_gnt", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (rsp_valid) begin
        chk("fair_id", 64'(rsp_id), 64'(rc % 4));
        chk("fair_sum", 64'(rsp_sum), 64'(32'h100 * (rc % 4 + 1) + rc % 4));
        rc++;
      end
      tick();
    end
    chk("fair_count", 64'(rc), 64'd8);
    chk("fair_drain_busy", 64'(busy), 64'd0);

    // Backpressure: six ops from requester 0, consumer stalls for three cycles.
    sent = 0;
    rc   = 0;
    for (int c = 0; c < 40 && rc < 6; c++) begin
      rsp_ready = !(c >= 5 && c <= 7);
      if (sent < 6) set_op(0, 32'(32'h10 * sent), 32'h7, 1'b0);
      else req_valid = '0;
      #1;
      if (c >= 5 && c <= 7) begin
        chk("bp_stop", 64'(add_stop), 64'd1);
        chk("bp_ready", 64'(req_ready), 64'd0);
      end
      hs = req_valid[0] & req_ready[0];
      if (rsp_valid) begin
        chk("bp_sum", 64'(rsp_sum), 64'(32'h10 * rc + 7));
        chk("bp_id", 64'(rsp_id), 64'd0);
        if (rsp_ready) rc++;
      end
      if (hs) sent++;
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    chk("bp_recv", 64'(rc), 64'd6);
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_drain_busy", 64'(busy), 64'd0);

    // Bubbles: requester 3 asks on every other cycle.
    rc = 0;
    for (int c = 0; c < 13; c++) begin
      if (c % 2 == 0 && c <= 6) set_op(3, 32'(c / 2), 32'h1000, 1'b0);
      else req_valid = '0;
      #1;
      exp_v = (c >= 4 && c <= 10 && c % 2 == 0);
      exp_b = (c >= 1 && c <= 10);
      chk("bub_valid", 64'(rsp_valid), 64'(exp_v));
      chk("bub_busy", 64'(busy), 64'(exp_b));
      if (rsp_valid) begin
        chk("bub_sum", 64'(rsp_sum), 64'(32'h1000 + rc));
        chk("bub_id", 64'(rsp_id), 64'd3);
        rc++;
      end
      tick();
    end
    chk("bub_count", 64'(rc), 64'd4);

    // Reset with three ops in flight; pointer is back at 0 after bubbles.
    for (int i = 0; i < 3; i++) set_op(i, 32'(i + 1), 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rf_gnt", 64'(req_ready), 64'(4'b0001 << c));
      tick();
    end
    chk("rf_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    set_op(3, 32'h9, 32'h9, 1'b0);
    #1;
    chk("rf_ready_in_rst", 64'(req_ready), 64'd0);
    tick();
    chk("rf_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rf_busy", 64'(busy), 64'd0);
    chk("rf_rsp_sum", 64'(rsp_sum), 64'd0);
    rst = 1'b0;
    #1;
    chk("rf_ptr_zero", 64'(req_ready), 64'b0001);
    req_valid = '0;
    run_single(2, 32'h5, 32'h6, 1'b1, 32'hC, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("rf_no_replay", 64'(rsp_valid), 64'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
